// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D memory-port arbiter.
package mem_arb_pkg;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the last_grant register resets to D,
// so I wins the first tie after reset.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req_i,
    input  logic   i_req_d,
    input  logic   i_update,
    output logic   o_grant_valid,
    output owner_t o_grant_id
);
    owner_t r_last_grant;

    always_comb begin
        o_grant_valid = i_req_i | i_req_d;
        if (i_req_i && i_req_d) o_grant_id = (r_last_grant == OWN_D) ? OWN_I : OWN_D;
        else if (i_req_d)       o_grant_id = OWN_D;
        else                    o_grant_id = OWN_I;
    end

    // NOTE: flops use non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)                            r_last_grant <= OWN_D;
        else if (i_update && o_grant_valid) r_last_grant <= o_grant_id;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shared memory-port controller: arbitrates I/D cache misses, sequences
// 8-word block fills and single-word writes, and streams fill words back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic [15:0]           fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_fill_valid,
    output logic                  d_fill_valid,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  busy
);
    localparam int                    OFF_W     = WORD_IDX_W + 1;  // byte-offset bits inside a block
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    state_t                  r_state;
    owner_t                  r_owner;
    logic [WORD_IDX_W-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]             r_wdata;

    logic                    w_grant_valid;
    owner_t                  w_grant_id;
    logic                    w_grant;
    logic [ADDR_WIDTH-1:0]   w_grant_addr;
    logic                    w_last;

    assign w_grant      = (r_state == IDLE) && w_grant_valid;
    assign w_grant_addr = (w_grant_id == OWN_D) ? d_addr : i_addr;
    assign w_last       = (r_cnt == LAST_WORD);

    rr_arb2 u_rr_arb2 (
        .clk           (clk),
        .rst           (rst),
        .i_req_i       (i_req),
        .i_req_d       (d_req),
        .i_update      (w_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant_valid) begin
                    r_owner <= w_grant_id;
                    r_cnt   <= '0;
                    r_addr  <= w_grant_addr & ~ADDR_WIDTH'(1);
                    r_wdata <= d_wdata;
                    r_state <= (w_grant_id == OWN_D && d_wr) ? WRITE : FILL;
                end
                FILL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state/owner/cnt and forced low while rst is
    // high, so an abandoned transaction never reaches the memory port.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_data    = '0;
        fill_word    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        busy         = (r_state != IDLE) && !rst;
        if (!rst) begin
            case (r_state)
                FILL: begin
                    mem_en       = 1'b1;
                    mem_addr     = {r_addr[ADDR_WIDTH-1:OFF_W], r_cnt, 1'b0};
                    fill_data    = mem_rdata;
                    fill_word    = r_cnt;
                    i_fill_valid = (r_owner == OWN_I);
                    d_fill_valid = (r_owner == OWN_D);
                    i_done       = (r_owner == OWN_I) && w_last;
                    d_done       = (r_owner == OWN_D) && w_last;
                end
                WRITE: begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                    d_done    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
